// File: rtl/aqfp_phase_stim_gen_pkg.sv
// Shared types for the AQFP phase/stimulus generator.
// logicAQFP token encoding, channel FSM states, value helpers.
package aqfp_pkg;

  typedef enum logic [1:0] {
    qZ = 2'b00,
    q1 = 2'b01,
    qX = 2'b10,
    q0 = 2'b11
  } logicAQFP;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DELAY,
    DRIVE
  } chan_state_e;

  function automatic logic is_valid_aqfp(input logic [1:0] v);
    return (v == q0) || (v == q1);
  endfunction

  // Only q0/q1 are legal drive values; anything else goes out as qX.
  function automatic logic [1:0] aqfp_drive(input logic [1:0] v);
    return is_valid_aqfp(v) ? v : qX;
  endfunction

endpackage

// File: rtl/aqfp_phase_stim_gen_if.sv
// Token bus between a stimulus source and aqfp_phase_stim_gen.
// master: tok_valid/tok_val/tok_gap out; slave: tok_ready/data_out/busy out.
interface aqfp_phase_stim_gen_if #(
  parameter int NUM_CH = 2,
  parameter int GAP_W  = 8
);
  logic [NUM_CH-1:0]       tok_valid;
  logic [NUM_CH-1:0]       tok_ready;
  logic [2*NUM_CH-1:0]     tok_val;
  logic [GAP_W*NUM_CH-1:0] tok_gap;
  logic [2*NUM_CH-1:0]     data_out;
  logic [NUM_CH-1:0]       busy;

  modport master (
    output tok_valid, tok_val, tok_gap,
    input  tok_ready, data_out, busy
  );

  modport slave (
    input  tok_valid, tok_val, tok_gap,
    output tok_ready, data_out, busy
  );
endinterface

// File: rtl/aqfp_chan_sender.sv
// One stimulus channel: accept token, wait gap strobes, delay, drive.
// Ports: clk, rst_n, strobe, tok_valid/val/gap in; tok_ready, data_out, busy (+err with AQFP_ERRCHK_EN) out.
module aqfp_chan_sender
  import aqfp_pkg::*;
#(
  parameter int GAP_W    = 8,
  parameter int DATA_DLY = 1,
  parameter int DATA_PW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic             tok_valid,
  input  logic [1:0]       tok_val,
  input  logic [GAP_W-1:0] tok_gap,
`ifdef AQFP_ERRCHK_EN
  output logic             err,
`endif
  output logic             tok_ready,
  output logic [1:0]       data_out,
  output logic             busy
);

  // DELAY always occupies at least one cycle.
  localparam int DLY_N = (DATA_DLY < 1) ? 1 : DATA_DLY;
  localparam int TMAX  = (DLY_N > DATA_PW) ? DLY_N : DATA_PW;
  localparam int TW    = $clog2(TMAX) + 1;

  chan_state_e      state;
  logic [1:0]       val;
  logic [GAP_W-1:0] gap;
  logic [TW-1:0]    tmr;
  logic             take;

  assign take = tok_valid & tok_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      val       <= qZ;
      gap       <= '0;
      tmr       <= '0;
      tok_ready <= 1'b0;
      data_out  <= qZ;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tok_ready <= ~take;
          if (take) begin
            val  <= tok_val;
            gap  <= tok_gap;
            busy <= 1'b1;
            if (tok_gap == '0) begin
              state <= DELAY;
              tmr   <= TW'(DLY_N - 1);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (strobe) begin
            gap <= gap - 1'b1;
            if (gap == GAP_W'(1)) begin
              state <= DELAY;
              tmr   <= TW'(DLY_N - 1);
            end
          end
        end
        DELAY: begin
          if (tmr == '0) begin
            state    <= DRIVE;
            tmr      <= TW'(DATA_PW - 1);
            data_out <= aqfp_drive(val);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        DRIVE: begin
          if (tmr == '0) begin
            state     <= IDLE;
            data_out  <= qZ;
            busy      <= 1'b0;
            tok_ready <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AQFP_ERRCHK_EN
  // Offer seen last cycle and not taken; dropping it now is a protocol error.
  logic pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= tok_valid & ~take;
      if ((take && !is_valid_aqfp(tok_val)) ||
          (pend && !tok_valid && !tok_ready))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/aqfp_phase_stim_gen.sv
// AQFP excitation phase generator with per-channel token stimulus.
// Ports: clk, rst_n, en; xio, dcio, sample_pt out; tok bus (slave); err with AQFP_ERRCHK_EN.
module aqfp_phase_stim_gen
  import aqfp_pkg::*;
#(
  parameter int NUM_PH   = 4,
  parameter int NUM_CH   = 2,
  parameter int PERIOD   = 16,
  parameter int PW       = 2,
  parameter int DATA_DLY = 1,
  parameter int DATA_PW  = 3,
  parameter int GAP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [NUM_PH-1:0] xio,
  output logic [NUM_PH-1:0] dcio,
  output logic [NUM_PH-1:0] sample_pt,
`ifdef AQFP_ERRCHK_EN
  output logic [NUM_CH-1:0] err,
`endif
  aqfp_phase_stim_gen_if.slave tok
);

  localparam int SEG = PERIOD / NUM_PH;
  localparam int CW  = $clog2(PERIOD);

  function automatic logic [NUM_PH-1:0] even_mask();
    logic [NUM_PH-1:0] m;
    for (int p = 0; p < NUM_PH; p++)
      m[p] = (p % 2 == 0);
    return m;
  endfunction

  localparam logic [NUM_PH-1:0] DC_LVL = even_mask();

  logic [CW-1:0]     cnt;
  int                cnt_i;
  logic [NUM_PH-1:0] xio_d;
  logic [NUM_PH-1:0] spt_d;

  assign cnt_i = int'(cnt);

  always_comb begin
    xio_d = '0;
    spt_d = '0;
    for (int p = 0; p < NUM_PH; p++) begin
      xio_d[p] = en && (cnt_i >= p * SEG) &&
                 (cnt_i < p * SEG + PW);
      spt_d[p] = en && (cnt_i == p * SEG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      xio       <= '0;
      dcio      <= '0;
      sample_pt <= '0;
    end else begin
      xio       <= xio_d;
      sample_pt <= spt_d;
      if (en) begin
        dcio <= DC_LVL;
        cnt  <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
      end
    end
  end

  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] bsy;
  logic [1:0]        dout [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    aqfp_chan_sender #(
      .GAP_W    (GAP_W),
      .DATA_DLY (DATA_DLY),
      .DATA_PW  (DATA_PW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .strobe    (sample_pt[c % NUM_PH]),
      .tok_valid (tok.tok_valid[c]),
      .tok_val   (tok.tok_val[2*c +: 2]),
      .tok_gap   (tok.tok_gap[GAP_W*c +: GAP_W]),
`ifdef AQFP_ERRCHK_EN
      .err       (err[c]),
`endif
      .tok_ready (rdy[c]),
      .data_out  (dout[c]),
      .busy      (bsy[c])
    );
  end

  always_comb begin
    tok.data_out = '0;
    for (int c = 0; c < NUM_CH; c++)
      tok.data_out[2*c +: 2] = dout[c];
  end

  assign tok.tok_ready = rdy;
  assign tok.busy      = bsy;

endmodule

// File: tb/tb_aqfp_phase_stim_gen.sv
// Directed bench for aqfp_phase_stim_gen (default parameters).
// Checks phases, gap timing, qX substitution, en pause, async reset.
module tb_aqfp_phase_stim_gen;
  import aqfp_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] xio;
  logic [3:0] dcio;
  logic [3:0] spt;
`ifdef AQFP_ERRCHK_EN
  logic [1:0] err;
`endif

  aqfp_phase_stim_gen_if #(.NUM_CH(2), .GAP_W(8)) tok ();

  aqfp_phase_stim_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .xio       (xio),
    .dcio      (dcio),
    .sample_pt (spt),
`ifdef AQFP_ERRCHK_EN
    .err       (err),
`endif
    .tok       (tok)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  function automatic logic [3:0] exp_xio(input int c);
    logic [3:0] e;
    for (int p = 0; p < 4; p++)
      e[p] = (c >= 4 * p) && (c < 4 * p + 2);
    return e;
  endfunction

  function automatic logic [3:0] exp_spt(input int c);
    logic [3:0] e;
    for (int p = 0; p < 4; p++)
      e[p] = (c == 4 * p);
    return e;
  endfunction

  initial begin
    tok.tok_valid = '0;
    tok.tok_val   = '0;
    tok.tok_gap   = '0;

    #12;
    chk("rst_xio", 32'(xio), 32'(0));
    chk("rst_dcio", 32'(dcio), 32'(0));
    chk("rst_spt", 32'(spt), 32'(0));
    chk("rst_dout", 32'(tok.data_out), 32'(0));
    chk("rst_ready", 32'(tok.tok_ready), 32'(0));
    chk("rst_busy", 32'(tok.busy), 32'(0));

    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_xio", 32'(xio), 32'(0));
    chk("idle_dcio", 32'(dcio), 32'(0));
    chk("idle_spt", 32'(spt), 32'(0));
    chk("idle_dout", 32'(tok.data_out), 32'(0));
    chk("idle_ready", 32'(tok.tok_ready), 32'(3));
    chk("idle_busy", 32'(tok.busy), 32'(0));

    // k = n means the sample after the n-th enabled edge.
    en = 1'b1;
    k  = -1;
    repeat (32) begin
      tick();
      chk("xio", 32'(xio), 32'(exp_xio(k % 16)));
      chk("sample_pt", 32'(spt), 32'(exp_spt(k % 16)));
      if (k == 0)
        chk("dcio", 32'(dcio), 32'(4'b0101));
    end

    // ch0: q1, gap 3; strobes seen at k=32,48,64
    tok.tok_valid = 2'b01;
    tok.tok_val   = 4'b0001;
    tok.tok_gap   = 16'h0003;
    tick();
    chk("gap_ready", 32'(tok.tok_ready), 32'(2'b10));
    chk("gap_busy", 32'(tok.busy), 32'(2'b01));
    chk("gap_spt", 32'(spt), 32'(4'b0001));
    tok.tok_valid = '0;
    while (k < 70) begin
      tick();
      chk("gap_dout0", 32'(tok.data_out[1:0]),
          32'((k >= 66 && k <= 68) ? q1 : qZ));
      chk("gap_dout1", 32'(tok.data_out[3:2]), 32'(qZ));
    end
    chk("gap_ready_end", 32'(tok.tok_ready), 32'(3));

    // ch1: qZ value, gap 0 -> qX
    tok.tok_valid = 2'b10;
    tok.tok_val   = 4'b0000;
    tok.tok_gap   = 16'h0000;
    tick();
    tok.tok_valid = '0;
    chk("inv_busy", 32'(tok.busy), 32'(2'b10));
    chk("inv_ready", 32'(tok.tok_ready), 32'(2'b01));
`ifdef AQFP_ERRCHK_EN
    chk("inv_err", 32'(err), 32'(2'b10));
`endif
    while (k < 76) begin
      tick();
      chk("inv_dout1", 32'(tok.data_out[3:2]),
          32'((k >= 72 && k <= 74) ? qX : qZ));
    end
`ifdef AQFP_ERRCHK_EN
    chk("inv_err_hold", 32'(err), 32'(2'b10));
`endif

    // ch0: q0, gap 2; en dropped after first strobe (k=80)
    tok.tok_valid = 2'b01;
    tok.tok_val   = 4'b0011;
    tok.tok_gap   = 16'h0002;
    tick();
    tok.tok_valid = '0;
    chk("pause_busy", 32'(tok.busy), 32'(2'b01));
    while (k < 80) tick();
    chk("pause_spt", 32'(spt), 32'(4'b0001));
    en = 1'b0;
    while (k < 120) begin
      tick();
      chk("pause_dout", 32'(tok.data_out[1:0]), 32'(qZ));
      chk("pause_xio", 32'(xio), 32'(0));
    end
    chk("pause_busy_hold", 32'(tok.busy), 32'(2'b01));
    en = 1'b1;
    // counter resumes from 1, next strobe at k=136
    while (k < 141) begin
      tick();
      chk("resume_dout", 32'(tok.data_out[1:0]),
          32'((k >= 138 && k <= 140) ? q0 : qZ));
    end
    chk("resume_ready", 32'(tok.tok_ready), 32'(3));

    // reset in the middle of DRIVE
    tok.tok_valid = 2'b01;
    tok.tok_val   = 4'b0001;
    tok.tok_gap   = 16'h0000;
    tick();
    tok.tok_valid = '0;
    tick();
    chk("mid_drive", 32'(tok.data_out[1:0]), 32'(q1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(tok.data_out), 32'(0));
    chk("arst_busy", 32'(tok.busy), 32'(0));
    chk("arst_cnt", 32'(dut.cnt), 32'(0));
    chk("arst_xio", 32'(xio), 32'(0));
    chk("arst_dcio", 32'(dcio), 32'(0));
    chk("arst_ready", 32'(tok.tok_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(tok.tok_ready), 32'(3));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
